// File: rtl/ddr_wr_arbiter.sv
// Round-robin N-to-1 AXI4 write-path arbiter for the MIG slave port.
// The winner owns AW, W and B for one whole burst; wlast comes from an internal beat counter.
module ddr_wr_arbiter #(
  parameter int CH     = 4,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH*ADDR_W-1:0] s_axi_awaddr,
  input  logic [CH*8-1:0]      s_axi_awlen,
  input  logic [CH-1:0]        s_axi_awvalid,
  output logic [CH-1:0]        s_axi_awready,
  input  logic [CH*DATA_W-1:0] s_axi_wdata,
  input  logic [CH-1:0]        s_axi_wvalid,
  output logic [CH-1:0]        s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic [CH-1:0]        s_axi_bvalid,
  input  logic [CH-1:0]        s_axi_bready,
  output logic [ID_W-1:0]      m_axi_awid,
  output logic [ADDR_W-1:0]    m_axi_awaddr,
  output logic [7:0]           m_axi_awlen,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [DATA_W-1:0]    m_axi_wdata,
  output logic                 m_axi_wlast,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic [1:0]           m_axi_bresp,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready
);

  localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  grant_reg, grant_next;
  logic [IDX_W-1:0]  last_reg, last_next;
  logic [7:0]        len_reg, len_next;
  logic [7:0]        beat_reg, beat_next;

  logic [IDX_W-1:0]  pick_idx;
  logic [7:0]        pick_len;
  logic              pick_found;
  logic [IDX_W:0]    cand;

  logic [CH-1:0]     grant_onehot;
  logic [ADDR_W-1:0] sel_awaddr;
  logic [7:0]        sel_awlen;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_wvalid;
  logic              sel_bready;

  // Per-channel handshakes are gated by the registered grant, so losers only ever see 0.
  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    assign grant_onehot[gi]  = (grant_reg == IDX_W'(gi));
    assign s_axi_awready[gi] = grant_onehot[gi] && (state_reg == ADDR) && m_axi_awready;
    assign s_axi_wready[gi]  = grant_onehot[gi] && (state_reg == DATA) && m_axi_wready;
    assign s_axi_bvalid[gi]  = grant_onehot[gi] && (state_reg == RESP) && m_axi_bvalid;
  end

  always_comb begin
    sel_awaddr = '0;
    sel_awlen  = '0;
    sel_wdata  = '0;
    sel_wvalid = 1'b0;
    sel_bready = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (grant_onehot[i]) begin
        sel_awaddr = s_axi_awaddr[i*ADDR_W +: ADDR_W];
        sel_awlen  = s_axi_awlen[i*8 +: 8];
        sel_wdata  = s_axi_wdata[i*DATA_W +: DATA_W];
        sel_wvalid = s_axi_wvalid[i];
        sel_bready = s_axi_bready[i];
      end
    end
  end

  // Search starts one past the last served channel and wraps, giving round-robin fairness.
  always_comb begin
    pick_idx   = '0;
    pick_len   = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= CH; k++) begin
      cand = {1'b0, last_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(CH)) begin
        cand = cand - (IDX_W+1)'(CH);
      end
      for (int i = 0; i < CH; i++) begin
        if (!pick_found && s_axi_awvalid[i] && (cand[IDX_W-1:0] == IDX_W'(i))) begin
          pick_idx   = IDX_W'(i);
          pick_len   = s_axi_awlen[i*8 +: 8];
          pick_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= IDX_W'(CH - 1);
      len_reg   <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      len_reg   <= len_next;
      beat_reg  <= beat_next;
    end
  end

  assign m_axi_awid = ID_W'(grant_reg);

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    last_next     = last_reg;
    len_next      = len_reg;
    beat_next     = beat_reg;
    m_axi_awvalid = 1'b0;
    m_axi_awaddr  = '0;
    m_axi_awlen   = '0;
    m_axi_wvalid  = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    s_axi_bresp   = '0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick_idx;
          len_next   = pick_len;
          state_next = ADDR;
        end
      end
      ADDR: begin
        m_axi_awvalid = 1'b1;
        m_axi_awaddr  = sel_awaddr;
        m_axi_awlen   = sel_awlen;
        if (m_axi_awready) begin
          beat_next  = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        m_axi_wvalid = sel_wvalid;
        m_axi_wdata  = sel_wdata;
        m_axi_wlast  = (beat_reg == len_reg);
        if (sel_wvalid && m_axi_wready) begin
          // The final beat leaves the counter alone so len=255 never wraps it.
          if (beat_reg == len_reg) begin
            state_next = RESP;
          end else begin
            beat_next = beat_reg + 8'd1;
          end
        end
      end
      RESP: begin
        m_axi_bready = sel_bready;
        s_axi_bresp  = m_axi_bresp;
        if (m_axi_bvalid && sel_bready) begin
          last_next  = grant_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/ddr_wr_arbiter.md
# ddr_wr_arbiter

Parametrised N-channel AXI4 write-path arbiter placed between several independent FIFO-based write masters and the single MIG AXI slave port of the DDR3 interface. Masters compete for the write address channel; the winner is chosen round-robin and owns the AW, W and B channels for one complete burst. The block generates `m_axi_wlast` from its own beat counter and routes the write response back to the owning master only. Downstream `awsize`, `awburst` and `wstrb` are fixed constants driven by the enclosing wrapper.

## Interface
- `CH`, 4: number of upstream write masters (1..16).
- `ADDR_W`, 30: byte address width.
- `DATA_W`, 64: data width.
- `ID_W`, 4: downstream ID width; must satisfy `CH` <= 2^`ID_W`.
- `clk` in 1: single clock for the whole block (MIG `ui_clk`).
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axi_awaddr` in `CH*ADDR_W`: per-channel burst start address, packed with channel 0 in the LSBs.
- `s_axi_awlen` in `CH*8`: per-channel burst length minus 1.
- `s_axi_awvalid` in `CH`: per-channel address request.
- `s_axi_awready` out `CH`: address accepted; only the granted bit can be 1.
- `s_axi_wdata` in `CH*DATA_W`: per-channel write data.
- `s_axi_wvalid` in `CH`: per-channel data valid.
- `s_axi_wready` out `CH`: data accepted; only the granted bit can be 1.
- `s_axi_bresp` out 2: response code, broadcast to all channels.
- `s_axi_bvalid` out `CH`: response valid; only the granted bit can be 1.
- `s_axi_bready` in `CH`: per-channel response ready.
- `m_axi_awid` out `ID_W`: granted channel index, zero-extended.
- `m_axi_awaddr` out `ADDR_W`: address of the granted channel.
- `m_axi_awlen` out 8: length of the granted channel.
- `m_axi_awvalid` out 1: downstream address valid.
- `m_axi_awready` in 1: downstream address ready.
- `m_axi_wdata` out `DATA_W`: data of the granted channel.
- `m_axi_wlast` out 1: last beat, generated internally.
- `m_axi_wvalid` out 1: downstream data valid.
- `m_axi_wready` in 1: downstream data ready.
- `m_axi_bresp` in 2: downstream response code.
- `m_axi_bvalid` in 1: downstream response valid.
- `m_axi_bready` out 1: downstream response ready.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Registers: `grant` (channel index), `last` (previously served channel), `len` (8 bits), `beat` (8 bits).
- **IDLE:**
  - If any `s_axi_awvalid` bit is set, `grant` takes the first requesting channel searching from (`last`+1) mod `CH` upward, wrapping around.
  - `len` captures that channel's `awlen`.
  - Next state is ADDR.
- **ADDR:**
  - `m_axi_awvalid` = 1. `m_axi_awaddr`/`m_axi_awlen` are muxed from `grant`.
  - `s_axi_awready[grant]` = `m_axi_awready`.
  - On handshake: `beat` is set to 0 and the state goes to DATA.
- **DATA:**
  - `m_axi_wvalid` = `s_axi_wvalid[grant]`; `s_axi_wready[grant]` = `m_axi_wready`.
  - `m_axi_wlast` = (`beat` == `len`).
  - Each beat handshake increments `beat`. The handshake with `m_axi_wlast` = 1 moves the state to RESP.
  - There is no upstream wlast; masters supply exactly `awlen`+1 beats.
- **RESP:**
  - `m_axi_bready` = `s_axi_bready[grant]`; `s_axi_bvalid[grant]` = `m_axi_bvalid`.
  - On handshake: `last` <= `grant` and the state returns to IDLE.
- All non-granted ready and valid outputs are 0 in every state.
- All ready/valid muxing is combinational from the registered `grant`. There is no buffering, so each handshake completes in the same cycle it occurs downstream.
- `m_axi_bresp` is forwarded unmodified, including SLVERR/DECERR. `m_axi_awid` = `grant`.
- `CH` = 1: the channel index is always 0; FSM behaviour is otherwise unchanged.
- `awlen` = 0: single beat, with `m_axi_wlast` high on the first beat. `awlen` = 255: 256 beats, with no counter overflow.

## Timing
- **Reset values:** state IDLE, `grant` 0, `last` `CH`-1 (so channel 0 has first priority), `len` 0, `beat` 0. All valid/ready outputs are 0; `m_axi_awid` is 0.
- **Address latency:** a request sampled in IDLE at edge n gives `m_axi_awvalid` = 1 from cycle n+1.
- **Back-to-back bursts:** after the B handshake at edge n, the earliest next `m_axi_awvalid` is cycle n+2, because one IDLE cycle is always spent.
- **Stalls:** a master dropping `awvalid` or `wvalid` simply stalls the corresponding stage. The grant is held until the B handshake; there is no timeout.
- **Request changes:** requests arriving or dropping during ADDR/DATA/RESP do not change `grant`.
- **Reset mid-burst:** asserting `rst_n` low during any state clears all outputs immediately and returns the FSM to IDLE. The partial burst is abandoned.

## Test plan
- After reset, channels 0 and 2 assert awvalid with `awlen`=3 in the same cycle -> channel 0 is served first with `m_axi_awid`=0, 4 beats, and `m_axi_wlast` only on beat 4. Channel 2 follows with `m_axi_awid`=2.
- All 4 channels request continuously with `awlen`=0 -> grant order is 0,1,2,3,0,1, with one IDLE cycle between each B handshake and the next awvalid.
- `awlen`=255 with `m_axi_wready` toggling every cycle -> exactly 256 beat handshakes, with `m_axi_wlast` high only on the 256th.
- Channel 1 is granted, `m_axi_bvalid`=1 with `bresp`=2'b10, and `s_axi_bready[1]`=0 for 5 cycles -> the FSM holds RESP and no other channel's awready rises. `s_axi_bvalid` equals 4'b0010 and `s_axi_bresp` equals 2'b10 until the handshake.
- `rst_n` is pulsed low after beat 2 of a 4-beat burst on channel 3 -> all outputs are 0 in that cycle. After release, simultaneous requests from channels 0 and 3 grant channel 0 first.
